// File: rtl/pixel_to_address_pkg.sv
// -----------------------------------------------------------------------------
// pixel_to_address_pkg
// Shared definitions for the pixel-to-cell-address converter:
//   - default cell geometry (edge length, gap, pitch, cells per axis)
//   - datapath widths
//   - converter FSM state encoding
// -----------------------------------------------------------------------------
package pixel_to_address_pkg;

    localparam int DEF_WIDTH   = 20;                      // cell edge length (pixels)
    localparam int DEF_SPACING = 5;                       // gap between cells (pixels)
    localparam int DEF_PITCH   = DEF_WIDTH + DEF_SPACING; // cell + gap
    localparam int DEF_GRID    = 16;                      // cells per axis

    localparam int PIXEL_W = 11;  // pixel coordinate / remainder width
    localparam int QUOT_W  = 5;   // quotient width; must hold GRID itself

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/axis_divider.sv
// -----------------------------------------------------------------------------
// axis_divider
// One-axis repeated-subtraction divider. On load the pixel coordinate becomes
// the remainder and the quotient clears; while enabled, each cycle in which
// the remainder still covers a full pitch (and the quotient has not reached
// GRID) subtracts one pitch and bumps the quotient.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset
//   load_i    in   latch pixel_i, clear quotient
//   enable_i  in   allow stepping this cycle
//   pixel_i   in   coordinate to divide
//   rem_o     out  current remainder
//   quot_o    out  current quotient (saturates at GRID)
//   step_o    out  a step is possible from the current state
// -----------------------------------------------------------------------------
module axis_divider
    import pixel_to_address_pkg::*;
#(
    parameter int PITCH = DEF_PITCH,
    parameter int GRID  = DEF_GRID
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               enable_i,
    input  logic [PIXEL_W-1:0] pixel_i,
    output logic [PIXEL_W-1:0] rem_o,
    output logic [QUOT_W-1:0]  quot_o,
    output logic               step_o
);

    localparam logic [PIXEL_W-1:0] PITCH_P = PIXEL_W'(PITCH);
    localparam logic [QUOT_W-1:0]  GRID_Q  = QUOT_W'(GRID);

    logic [PIXEL_W-1:0] rem_q, rem_d;
    logic [QUOT_W-1:0]  quot_q, quot_d;

    // Quotient stops at GRID so out-of-range pixels terminate in bounded time.
    assign step_o = (rem_q >= PITCH_P) && (quot_q < GRID_Q);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rem_d  = rem_q;
        quot_d = quot_q;
        if (load_i) begin
            rem_d  = pixel_i;
            quot_d = '0;
        end else if (enable_i && step_o) begin
            rem_d  = rem_q - PITCH_P;
            quot_d = quot_q + QUOT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            rem_q  <= '0;
            quot_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
        end
    end

    assign rem_o  = rem_q;
    assign quot_o = quot_q;

endmodule

// File: rtl/pixel_to_address.sv
// -----------------------------------------------------------------------------
// pixel_to_address
// Converts a pixel (pixelX, pixelY) into the cell grid position it falls in.
// Both axes are divided by the cell pitch in parallel by repeated subtraction;
// when neither axis can step any further the result is registered and shown
// together with a one-cycle done pulse.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset (wins over start)
//   start       in   request conversion (accepted only when idle)
//   pixelX/Y    in   11-bit pixel coordinates
//   busy        out  conversion in progress
//   done        out  one-cycle pulse, results valid from this cycle
//   positionX/Y out  cell column/row
//   address     out  16*positionY + positionX
//   hit         out  pixel lies inside a cell body (not in a gap)
//   outOfRange  out  pixel lies beyond the grid on either axis
// -----------------------------------------------------------------------------
module pixel_to_address
    import pixel_to_address_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SPACING = DEF_SPACING,
    parameter int GRID    = DEF_GRID
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [PIXEL_W-1:0] pixelX,
    input  logic [PIXEL_W-1:0] pixelY,
    output logic               busy,
    output logic               done,
    output logic [3:0]         positionX,
    output logic [3:0]         positionY,
    output logic [8:0]         address,
    output logic               hit,
    output logic               outOfRange
);

    localparam int                 PITCH   = WIDTH + SPACING;
    localparam logic [PIXEL_W-1:0] WIDTH_P = PIXEL_W'(WIDTH);
    localparam logic [QUOT_W-1:0]  GRID_Q  = QUOT_W'(GRID);

    state_t state_q, state_d;

    logic               load, calc, finish;
    logic [PIXEL_W-1:0] rem_x, rem_y;
    logic [QUOT_W-1:0]  quot_x, quot_y;
    logic               step_x, step_y;

    logic [3:0] pos_x_q, pos_x_d;
    logic [3:0] pos_y_q, pos_y_d;
    logic       hit_q, hit_d;
    logic       oor_q, oor_d;

    assign load   = (state_q == S_IDLE) && start;
    assign calc   = (state_q == S_CALC);
    assign finish = calc && !step_x && !step_y;

    axis_divider #(.PITCH(PITCH), .GRID(GRID)) u_div_x (
        .clock    (clock),
        .reset    (reset),
        .load_i   (load),
        .enable_i (calc),
        .pixel_i  (pixelX),
        .rem_o    (rem_x),
        .quot_o   (quot_x),
        .step_o   (step_x)
    );

    axis_divider #(.PITCH(PITCH), .GRID(GRID)) u_div_y (
        .clock    (clock),
        .reset    (reset),
        .load_i   (load),
        .enable_i (calc),
        .pixel_i  (pixelY),
        .rem_o    (rem_y),
        .quot_o   (quot_y),
        .step_o   (step_y)
    );

    // Next-state logic; start outside IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_CALC;
            S_CALC:  if (finish) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Results are captured on the last CALC cycle so they are visible in DONE
    // and then held until the next conversion completes.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        hit_d   = hit_q;
        oor_d   = oor_q;
        if (finish) begin
            oor_d = (quot_x == GRID_Q) || (quot_y == GRID_Q);
            if (oor_d) begin
                pos_x_d = '0;
                pos_y_d = '0;
                hit_d   = 1'b0;
            end else begin
                pos_x_d = quot_x[3:0];
                pos_y_d = quot_y[3:0];
                hit_d   = (rem_x < WIDTH_P) && (rem_y < WIDTH_P);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            hit_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            hit_q   <= hit_d;
            oor_q   <= oor_d;
        end
    end

    assign busy       = calc;
    assign done       = (state_q == S_DONE);
    assign positionX  = pos_x_q;
    assign positionY  = pos_y_q;
    assign address    = {1'b0, pos_y_q, pos_x_q};
    assign hit        = hit_q;
    assign outOfRange = oor_q;

endmodule

// File: tb/tb_pixel_to_address.sv
// -----------------------------------------------------------------------------
// tb_pixel_to_address
// Directed self-checking bench for pixel_to_address. Cycle k starts at rising
// edge k; inputs change 1 time unit after the edge, outputs are sampled on the
// falling edge. A start driven in cycle 0 is accepted at the edge opening
// cycle 1.
// -----------------------------------------------------------------------------
module tb_pixel_to_address;

    logic        clock;
    logic        reset;
    logic        start;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        busy;
    logic        done;
    logic [3:0]  positionX;
    logic [3:0]  positionY;
    logic [8:0]  address;
    logic        hit;
    logic        outOfRange;

    int tests_run    = 0;
    int tests_failed = 0;
    int prev_addr    = 0;   // result the outputs must hold while converting

    pixel_to_address dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .busy       (busy),
        .done       (done),
        .positionX  (positionX),
        .positionY  (positionY),
        .address    (address),
        .hit        (hit),
        .outOfRange (outOfRange)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one conversion starting in the next cycle (cycle 0). If extra_cyc
    // is non-negative, a second start with (0,0) is driven in that cycle.
    task automatic convert(input string tag,
                           input int x, input int y,
                           input int exp_cyc,
                           input int exp_px, input int exp_py, input int exp_addr,
                           input int exp_hit, input int exp_oor,
                           input int extra_cyc);
        int cyc;
        bit got_done;
        @(posedge clock); #1;
        start  = 1'b1;
        pixelX = 11'(x);
        pixelY = 11'(y);
        @(posedge clock); #1;
        start  = 1'b0;
        cyc      = 1;
        got_done = 1'b0;
        @(negedge clock);
        check({tag, " busy c1"}, 32'(busy), 32'd1);
        check({tag, " hold c1"}, 32'(address), 32'(prev_addr));
        while (!got_done && cyc < 40) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                @(posedge clock); #1;
                cyc++;
                if (cyc == extra_cyc) begin
                    start  = 1'b1;
                    pixelX = 11'd0;
                    pixelY = 11'd0;
                end else begin
                    start = 1'b0;
                end
                @(negedge clock);
            end
        end
        start = 1'b0;
        check({tag, " done seen"}, 32'(got_done), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        check({tag, " posX"}, 32'(positionX), 32'(exp_px));
        check({tag, " posY"}, 32'(positionY), 32'(exp_py));
        check({tag, " addr"}, 32'(address), 32'(exp_addr));
        check({tag, " hit"}, 32'(hit), 32'(exp_hit));
        check({tag, " oor"}, 32'(outOfRange), 32'(exp_oor));
        @(posedge clock); #1;
        @(negedge clock);
        check({tag, " done 1cyc"}, 32'(done), 32'd0);
        check({tag, " busy idle"}, 32'(busy), 32'd0);
        check({tag, " addr held"}, 32'(address), 32'(exp_addr));
        prev_addr = exp_addr;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " posX"}, 32'(positionX), 32'd0);
        check({tag, " posY"}, 32'(positionY), 32'd0);
        check({tag, " addr"}, 32'(address), 32'd0);
        check({tag, " hit"}, 32'(hit), 32'd0);
        check({tag, " oor"}, 32'(outOfRange), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        pixelX = '0;
        pixelY = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_cleared("reset");

        //       tag         x     y    cyc px py addr hit oor extra
        convert("origin",    0,    0,    2,  0, 0,   0, 1, 0, -1);
        convert("c1_5",     30,  130,    7,  1, 5,  81, 1, 0, -1);
        convert("corner",  399,  399,   17, 15,15, 255, 0, 0, -1);
        convert("oor_x",   400,   10,   18,  0, 0,   0, 0, 1, -1);
        convert("gapx",     20,    0,    2,  0, 0,   0, 0, 0, -1);
        convert("edge19",   19,   19,    2,  0, 0,   0, 1, 0, -1);
        convert("gapx_y1",  24,   25,    3,  0, 1,  16, 0, 0, -1);
        convert("row15",    10,  380,   17,  0,15, 240, 1, 0, -1);
        convert("oor_y",     0,  400,   18,  0, 0,   0, 0, 1, -1);
        convert("oor_max",2047,    0,   18,  0, 0,   0, 0, 1, -1);
        convert("c12_3",   300,   75,   14, 12, 3,  60, 1, 0, -1);
        convert("ign_start",399, 399,   17, 15,15, 255, 0, 0,  3);

        // Reset mid-conversion: start (399,399) in cycle 0, reset in cycle 5.
        @(posedge clock); #1;
        start  = 1'b1;
        pixelX = 11'd399;
        pixelY = 11'd399;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;                    // cycle 5
        @(posedge clock); #1;
        reset = 1'b0;                    // cycle 6
        @(negedge clock);
        check_cleared("midreset");
        prev_addr = 0;
        convert("after_rst", 30, 130,  7,  1, 5,  81, 1, 0, -1);

        // Reset and start together: reset wins, nothing starts.
        @(posedge clock); #1;
        reset  = 1'b1;
        start  = 1'b1;
        pixelX = 11'd30;
        pixelY = 11'd130;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check_cleared("rst_vs_start");
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_vs_start busy+1", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
